// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target: FSM state encoding,
// the read-only ID addresses and the power-on register contents.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } sccb_state_e;

  localparam logic [7:0] ADDR_PID = 8'h0A;
  localparam logic [7:0] ADDR_VER = 8'h0B;

  function automatic logic [7:0] reg_default(input logic [7:0] addr,
                                             input logic [7:0] pid,
                                             input logic [7:0] ver);
    case (addr)
      ADDR_PID: reg_default = pid;
      ADDR_VER: reg_default = ver;
      default:  reg_default = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/sccb_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for one open-drain line.
// Output follows the pad 2+FILT_LEN cycles later; no backpressure, resets to idle-high.
module sccb_line_filter #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic line_in,
  output logic line_filt
);

  logic [1:0] sync_q;
  logic [3:0] cnt_q;

  // cnt_q counts consecutive synchronized samples that disagree with the output
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync_q    <= 2'b11;
      cnt_q     <= '0;
      line_filt <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], line_in};
      if (sync_q[1] == line_filt) begin
        cnt_q <= '0;
      end else if (cnt_q == 4'(FILT_LEN - 1)) begin
        line_filt <= sync_q[1];
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/sccb_slave_responder.sv
// SCCB/I2C register-set target with a 256x8 flop register file and write strobe.
// Line events seen 2+FILT_LEN cycles after the pad; SDA changes only after SCL falls.
module sccb_slave_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0]  DEV_ID   = 8'h60,
  parameter int unsigned FILT_LEN = 3,
  parameter logic [7:0]  PID_VAL  = 8'h26,
  parameter logic [7:0]  VER_VAL  = 8'h42
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_scl,
  input  logic       I_sda,
  output logic       O_sda_oe,
  output logic       O_reg_wr,
  output logic [7:0] O_reg_addr,
  output logic [7:0] O_reg_data,
  output logic       O_busy
);

  logic        scl_f, sda_f, scl_q, sda_q;
  logic        scl_rise, scl_fall, start_det, stop_det;
  sccb_state_e state_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  sub_addr_q;
  logic [7:0]  sub_addr_inc;
  logic [7:0]  rx_byte;
  logic        rw_q;
  logic        mack_q;
  logic [7:0]  regs_q [256];

  sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .I_clk     (I_clk),
    .I_rst_n   (I_rst_n),
    .line_in   (I_scl),
    .line_filt (scl_f)
  );

  sccb_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .I_clk     (I_clk),
    .I_rst_n   (I_rst_n),
    .line_in   (I_sda),
    .line_filt (sda_f)
  );

  assign scl_rise     = scl_f & ~scl_q;
  assign scl_fall     = ~scl_f & scl_q;
  assign start_det    = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det     = scl_f & scl_q & ~sda_q & sda_f;
  assign rx_byte      = {shift_q[6:0], sda_f};
  assign sub_addr_inc = sub_addr_q + 8'd1;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      sub_addr_q <= '0;
      rw_q       <= 1'b0;
      mack_q     <= 1'b1;
      O_sda_oe   <= 1'b0;
      O_reg_wr   <= 1'b0;
      O_reg_addr <= '0;
      O_reg_data <= '0;
      O_busy     <= 1'b0;
    end else begin
      scl_q    <= scl_f;
      sda_q    <= sda_f;
      O_reg_wr <= 1'b0;
      if (start_det) begin
        state_q   <= ST_ID;
        bit_cnt_q <= '0;
        O_sda_oe  <= 1'b0;
        O_busy    <= 1'b1;
      end else if (stop_det) begin
        state_q  <= ST_IDLE;
        O_sda_oe <= 1'b0;
        O_busy   <= 1'b0;
      end else begin
        case (state_q)
          ST_ID: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) rw_q <= sda_f;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              if (shift_q[7:1] == DEV_ID[7:1]) begin
                O_sda_oe <= 1'b1;
                state_q  <= ST_ID_ACK;
              end else begin
                state_q <= ST_IDLE;
                O_busy  <= 1'b0;
              end
            end
          end
          ST_ID_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= '0;
              if (rw_q) begin
                // first read bit goes out on the same edge that ends the ACK
                shift_q  <= regs_q[sub_addr_q];
                O_sda_oe <= ~regs_q[sub_addr_q][7];
                state_q  <= ST_RDATA;
              end else begin
                O_sda_oe <= 1'b0;
                state_q  <= ST_SUB;
              end
            end
          end
          ST_SUB: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) sub_addr_q <= rx_byte;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              O_sda_oe <= 1'b1;
              state_q  <= ST_SUB_ACK;
            end
          end
          ST_WDATA: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7 && sub_addr_q != ADDR_PID && sub_addr_q != ADDR_VER) begin
                O_reg_wr   <= 1'b1;
                O_reg_addr <= sub_addr_q;
                O_reg_data <= rx_byte;
              end
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              O_sda_oe <= 1'b1;
              state_q  <= ST_WDATA_ACK;
            end
          end
          ST_SUB_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              O_sda_oe  <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= ST_WDATA;
              if (state_q == ST_WDATA_ACK) sub_addr_q <= sub_addr_inc;
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                O_sda_oe <= 1'b0;
                state_q  <= ST_RDATA_ACK;
              end else begin
                shift_q  <= {shift_q[6:0], 1'b0};
                O_sda_oe <= ~shift_q[6];
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              mack_q <= sda_f;
            end else if (scl_fall) begin
              if (!mack_q) begin
                sub_addr_q <= sub_addr_inc;
                shift_q    <= regs_q[sub_addr_inc];
                O_sda_oe   <= ~regs_q[sub_addr_inc][7];
                bit_cnt_q  <= '0;
                state_q    <= ST_RDATA;
              end else begin
                state_q <= ST_WAIT_STOP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Commits the strobed write one cycle after O_reg_wr; reads happen bytes later.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < 256; i++) regs_q[i] <= reg_default(8'(i), PID_VAL, VER_VAL);
    end else if (O_reg_wr) begin
      regs_q[O_reg_addr] <= O_reg_data;
    end
  end

endmodule

// File: tb/tb_sccb_slave_responder.sv
// Directed SCCB master driving the responder; writes and read bytes are checked
// against scoreboard queues filled when each transaction is issued.
module tb_sccb_slave_responder;

  localparam int FILT_LEN = 3;
  localparam int Q        = 10;

  logic       I_clk = 1'b0;
  logic       I_rst_n;
  logic       m_scl, m_sda;
  logic       O_sda_oe, O_reg_wr, O_busy;
  logic [7:0] O_reg_addr, O_reg_data;
  wire        sda_bus = m_sda & ~O_sda_oe;

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] wr_exp_q[$];
  logic [7:0]  rd_exp_q[$];

  sccb_slave_responder #(
    .DEV_ID(8'h60), .FILT_LEN(FILT_LEN), .PID_VAL(8'h26), .VER_VAL(8'h42)
  ) dut (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_scl      (m_scl),
    .I_sda      (sda_bus),
    .O_sda_oe   (O_sda_oe),
    .O_reg_wr   (O_reg_wr),
    .O_reg_addr (O_reg_addr),
    .O_reg_data (O_reg_data),
    .O_busy     (O_busy)
  );

  always #5 I_clk = ~I_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every strobe must match the next queued write; a strobe with nothing queued fails.
  always @(negedge I_clk) begin
    if (I_rst_n && O_reg_wr) begin
      chk("wr_pulse_expected", 16'(O_reg_wr), 16'(wr_exp_q.size() != 0));
      if (wr_exp_q.size() != 0) chk("wr_addr_data", {O_reg_addr, O_reg_data}, wr_exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge I_clk);
  endtask

  task automatic bus_start();
    tick(Q); m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
  endtask

  // One SCL period; samples the bus mid-high and O_sda_oe at both ends of the high phase.
  task automatic bit_io(input logic b, output logic s, output logic [1:0] oe);
    tick(Q); m_sda = b; tick(Q); m_scl = 1'b1;
    tick(Q); s = sda_bus; oe[1] = O_sda_oe;
    tick(Q); oe[0] = O_sda_oe; m_scl = 1'b0;
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b, input logic acked);
    logic s;
    logic [1:0] oe;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s, oe);
    bit_io(1'b1, s, oe);
    chk({tag, "_ack_sda"}, 16'(s), 16'(!acked));
    chk({tag, "_ack_oe"}, 16'(oe), acked ? 16'h0003 : 16'h0000);
  endtask

  task automatic read_byte(input string tag, input logic mack);
    logic s;
    logic [1:0] oe;
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s, oe);
      d[i] = s;
    end
    chk(tag, 16'(d), 16'(rd_exp_q.pop_front()));
    bit_io(mack, s, oe);
    chk({tag, "_mack_rel"}, 16'(oe), 16'h0000);
  endtask

  task automatic read_reg(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    bus_start();
    send_byte({tag, "_id"}, 8'h60, 1'b1);
    send_byte({tag, "_sub"}, addr, 1'b1);
    bus_start();
    send_byte({tag, "_rid"}, 8'h61, 1'b1);
    rd_exp_q.push_back(exp);
    read_byte(tag, 1'b1);
    bus_stop();
  endtask

  initial begin
    logic s;
    logic [1:0] oe;
    logic [7:0] id;
    m_scl = 1'b1; m_sda = 1'b1; I_rst_n = 1'b0;
    tick(3);
    chk("rst_oe", 16'(O_sda_oe), 16'h0);
    chk("rst_wr", 16'(O_reg_wr), 16'h0);
    chk("rst_addr", 16'(O_reg_addr), 16'h0);
    chk("rst_data", 16'(O_reg_data), 16'h0);
    chk("rst_busy", 16'(O_busy), 16'h0);
    I_rst_n = 1'b1;
    tick(5);

    // single write 0x12 <= 0x80
    bus_start();
    chk("w1_busy", 16'(O_busy), 16'h1);
    send_byte("w1_id", 8'h60, 1'b1);
    send_byte("w1_sub", 8'h12, 1'b1);
    wr_exp_q.push_back(16'h1280);
    send_byte("w1_dat", 8'h80, 1'b1);
    bus_stop();
    tick(2);
    chk("w1_busy_end", 16'(O_busy), 16'h0);
    chk("w1_hold", {O_reg_addr, O_reg_data}, 16'h1280);
    chk("w1_drain", 16'(wr_exp_q.size()), 16'h0);

    // repeated-start read of PID then VER
    bus_start();
    send_byte("r_id", 8'h60, 1'b1);
    send_byte("r_sub", 8'h0A, 1'b1);
    bus_start();
    send_byte("r_rid", 8'h61, 1'b1);
    rd_exp_q.push_back(8'h26);
    rd_exp_q.push_back(8'h42);
    read_byte("r_pid", 1'b0);
    read_byte("r_ver", 1'b1);
    tick(Q);
    chk("r_nack_rel", 16'(O_sda_oe), 16'h0);
    bus_stop();

    // foreign device ID is ignored
    bus_start();
    send_byte("bad_id", 8'h42, 1'b0);
    chk("bad_busy", 16'(O_busy), 16'h0);
    send_byte("bad_sub", 8'h12, 1'b0);
    send_byte("bad_dat", 8'h55, 1'b0);
    bus_stop();
    read_reg("bad_rb12", 8'h12, 8'h80);

    // burst write wrapping 0xFF -> 0x00
    bus_start();
    send_byte("b_id", 8'h60, 1'b1);
    send_byte("b_sub", 8'hFE, 1'b1);
    wr_exp_q.push_back(16'hFE11);
    send_byte("b_d0", 8'h11, 1'b1);
    wr_exp_q.push_back(16'hFF22);
    send_byte("b_d1", 8'h22, 1'b1);
    wr_exp_q.push_back(16'h0033);
    send_byte("b_d2", 8'h33, 1'b1);
    bus_stop();
    chk("b_drain", 16'(wr_exp_q.size()), 16'h0);
    read_reg("b_rb00", 8'h00, 8'h33);
    read_reg("b_rbff", 8'hFF, 8'h22);
    read_reg("b_rbfe", 8'hFE, 8'h11);

    // PID is read-only: ACKed, no strobe, value kept
    bus_start();
    send_byte("ro_id", 8'h60, 1'b1);
    send_byte("ro_sub", 8'h0A, 1'b1);
    send_byte("ro_dat", 8'h99, 1'b1);
    bus_stop();
    read_reg("ro_rbpid", 8'h0A, 8'h26);

    // short SDA glitch while SCL high must not look like START
    tick(Q);
    m_sda = 1'b0;
    tick(FILT_LEN - 1);
    m_sda = 1'b1;
    tick(Q);
    chk("glitch_busy", 16'(O_busy), 16'h0);

    // STOP in the middle of the sub-address byte
    bus_start();
    send_byte("p_id", 8'h60, 1'b1);
    id = 8'h34;
    for (int i = 7; i >= 4; i--) bit_io(id[i], s, oe);
    chk("p_no_ack", 16'(oe), 16'h0);
    bus_stop();
    tick(2);
    chk("p_busy", 16'(O_busy), 16'h0);
    chk("p_oe", 16'(O_sda_oe), 16'h0);

    // reset asserted while the slave drives the ID ACK
    bus_start();
    id = 8'h60;
    for (int i = 7; i >= 0; i--) bit_io(id[i], s, oe);
    tick(Q); m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q);
    chk("ra_pre_oe", 16'(O_sda_oe), 16'h1);
    I_rst_n = 1'b0;
    #1;
    chk("ra_oe", 16'(O_sda_oe), 16'h0);
    chk("ra_busy", 16'(O_busy), 16'h0);
    tick(5);
    I_rst_n = 1'b1;
    tick(2 * Q);
    read_reg("ra_rb12", 8'h12, 8'h00);
    read_reg("ra_rbpid", 8'h0A, 8'h26);
    read_reg("ra_rbver", 8'h0B, 8'h42);

    tick(Q);
    chk("final_drain", 16'(wr_exp_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
